// File: rtl/frame_buf_sched_if.sv
// Channel, memory-port and bank-status signals of the frame-buffer scheduler.
// master = scheduler side, slave = pipeline/memory side.
interface frame_buf_sched_if #(
  parameter int OFFSET_WIDTH = 22,
  parameter int LEN_WIDTH    = 10
);
  logic                      read_req;
  logic                      read_req_ack;
  logic                      wr_frame_done;

  logic                      wr_burst_req;
  logic [LEN_WIDTH-1:0]      wr_burst_len;
  logic [OFFSET_WIDTH-1:0]   wr_burst_offset;
  logic                      wr_burst_ack;
  logic                      wr_burst_finish;

  logic                      rd_burst_req;
  logic [LEN_WIDTH-1:0]      rd_burst_len;
  logic [OFFSET_WIDTH-1:0]   rd_burst_offset;
  logic                      rd_burst_ack;
  logic                      rd_burst_finish;

  logic                      mem_burst_req;
  logic                      mem_burst_rw;
  logic [OFFSET_WIDTH+1:0]   mem_burst_addr;
  logic [LEN_WIDTH-1:0]      mem_burst_len;
  logic                      mem_burst_ack;
  logic                      mem_burst_finish;

  logic [1:0]                wr_bank;
  logic [1:0]                rd_bank;

  modport master (
    input  read_req, wr_frame_done,
    input  wr_burst_req, wr_burst_len, wr_burst_offset,
    input  rd_burst_req, rd_burst_len, rd_burst_offset,
    input  mem_burst_ack, mem_burst_finish,
    output read_req_ack,
    output wr_burst_ack, wr_burst_finish,
    output rd_burst_ack, rd_burst_finish,
    output mem_burst_req, mem_burst_rw, mem_burst_addr, mem_burst_len,
    output wr_bank, rd_bank
  );

  modport slave (
    output read_req, wr_frame_done,
    output wr_burst_req, wr_burst_len, wr_burst_offset,
    output rd_burst_req, rd_burst_len, rd_burst_offset,
    output mem_burst_ack, mem_burst_finish,
    input  read_req_ack,
    input  wr_burst_ack, wr_burst_finish,
    input  rd_burst_ack, rd_burst_finish,
    input  mem_burst_req, mem_burst_rw, mem_burst_addr, mem_burst_len,
    input  wr_bank, rd_bank
  );
endinterface

// File: rtl/frame_buf_sched.sv
// Frame-buffer burst scheduler with triple-buffer bank rotation.
// Optional READ_PRIORITY_EN: read channel always wins simultaneous requests.
module frame_buf_sched #(
  parameter int OFFSET_WIDTH = 22,
  parameter int LEN_WIDTH    = 10
) (
  input  logic                 clk,
  input  logic                 rst_n,
  frame_buf_sched_if.master    bus
);

  localparam int AW = OFFSET_WIDTH + 2;
  localparam logic CH_RD = 1'b0;
  localparam logic CH_WR = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_BUSY = 2'd2
  } state_t;

  state_t               state_r;
  logic                 sel_r;
  logic                 rr_last_r;
  logic [1:0]           wr_bank_r;
  logic [1:0]           rd_bank_r;
  logic [1:0]           last_bank_r;
  logic                 read_req_ack_r;
  logic                 mem_burst_req_r;
  logic                 mem_burst_rw_r;
  logic [AW-1:0]        mem_burst_addr_r;
  logic [LEN_WIDTH-1:0] mem_burst_len_r;

  logic                 grant_s;
  logic                 any_req_s;
  logic                 ack_s;
  logic                 fin_s;
  logic                 rr_accept_s;

  // The bank in {0,1,2} that is neither a nor b (a != b).
  function automatic logic [1:0] third_bank(input logic [1:0] a, input logic [1:0] b);
    third_bank = 2'd3 - a - b;
  endfunction

  // Channel arbitration for the next burst.
  always_comb begin
    grant_s = CH_WR;
    if (bus.rd_burst_req && bus.wr_burst_req) begin
`ifdef READ_PRIORITY_EN
      grant_s = CH_RD;
`else
      grant_s = (rr_last_r == CH_WR) ? CH_RD : CH_WR;
`endif
    end else if (bus.rd_burst_req) begin
      grant_s = CH_RD;
    end else begin
      grant_s = CH_WR;
    end
  end

  // Channel handshake pulses track the memory handshake in the same cycle.
  always_comb begin
    any_req_s   = bus.rd_burst_req | bus.wr_burst_req;
    ack_s       = (state_r == ST_REQ) && bus.mem_burst_ack;
    fin_s       = ((state_r == ST_BUSY) || ack_s) && bus.mem_burst_finish;
    rr_accept_s = bus.read_req && (state_r == ST_IDLE) && !read_req_ack_r;
  end

  // Triple-buffer bank rotation and display frame-start handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_bank_r      <= 2'd0;
      rd_bank_r      <= 2'd1;
      last_bank_r    <= 2'd1;
      read_req_ack_r <= 1'b0;
    end else begin
      read_req_ack_r <= rr_accept_s;
      if (rr_accept_s && bus.wr_frame_done) begin
        // The frame completing this cycle is the one shown.
        rd_bank_r   <= wr_bank_r;
        last_bank_r <= wr_bank_r;
        wr_bank_r   <= third_bank(wr_bank_r, rd_bank_r);
      end else if (rr_accept_s) begin
        rd_bank_r   <= last_bank_r;
      end else if (bus.wr_frame_done) begin
        last_bank_r <= wr_bank_r;
        wr_bank_r   <= third_bank(wr_bank_r, rd_bank_r);
      end else begin
        wr_bank_r   <= wr_bank_r;
      end
    end
  end

  // Burst FSM; the memory command is latched on IDLE->REQ and held until the next grant.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r          <= ST_IDLE;
      sel_r            <= CH_WR;
      rr_last_r        <= CH_WR;
      mem_burst_req_r  <= 1'b0;
      mem_burst_rw_r   <= 1'b0;
      mem_burst_addr_r <= {AW{1'b0}};
      mem_burst_len_r  <= {LEN_WIDTH{1'b0}};
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (any_req_s) begin
            state_r         <= ST_REQ;
            sel_r           <= grant_s;
            mem_burst_req_r <= 1'b1;
            mem_burst_rw_r  <= grant_s;
            if (grant_s == CH_WR) begin
              mem_burst_addr_r <= {wr_bank_r, bus.wr_burst_offset};
              mem_burst_len_r  <= bus.wr_burst_len;
            end else begin
              mem_burst_addr_r <= {rd_bank_r, bus.rd_burst_offset};
              mem_burst_len_r  <= bus.rd_burst_len;
            end
          end
        end
        ST_REQ: begin
          if (ack_s) begin
            mem_burst_req_r <= 1'b0;
            if (fin_s) begin
              state_r   <= ST_IDLE;
              rr_last_r <= sel_r;
            end else begin
              state_r   <= ST_BUSY;
            end
          end
        end
        ST_BUSY: begin
          if (fin_s) begin
            state_r   <= ST_IDLE;
            rr_last_r <= sel_r;
          end
        end
        default: begin
          state_r         <= ST_IDLE;
          mem_burst_req_r <= 1'b0;
        end
      endcase
    end
  end

  assign bus.read_req_ack    = read_req_ack_r;
  assign bus.wr_burst_ack    = ack_s && (sel_r == CH_WR);
  assign bus.rd_burst_ack    = ack_s && (sel_r == CH_RD);
  assign bus.wr_burst_finish = fin_s && (sel_r == CH_WR);
  assign bus.rd_burst_finish = fin_s && (sel_r == CH_RD);
  assign bus.mem_burst_req   = mem_burst_req_r;
  assign bus.mem_burst_rw    = mem_burst_rw_r;
  assign bus.mem_burst_addr  = mem_burst_addr_r;
  assign bus.mem_burst_len   = mem_burst_len_r;
  assign bus.wr_bank         = wr_bank_r;
  assign bus.rd_bank         = rd_bank_r;

endmodule

// File: tb/tb_frame_buf_sched.sv
// Directed self-checking bench for frame_buf_sched.
module tb_frame_buf_sched;
  localparam int OW = 22;
  localparam int LW = 10;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  frame_buf_sched_if #(.OFFSET_WIDTH(OW), .LEN_WIDTH(LW)) bus ();

  frame_buf_sched #(.OFFSET_WIDTH(OW), .LEN_WIDTH(LW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus.read_req         = 1'b0;
    bus.wr_frame_done    = 1'b0;
    bus.wr_burst_req     = 1'b0;
    bus.wr_burst_len     = '0;
    bus.wr_burst_offset  = '0;
    bus.rd_burst_req     = 1'b0;
    bus.rd_burst_len     = '0;
    bus.rd_burst_offset  = '0;
    bus.mem_burst_ack    = 1'b0;
    bus.mem_burst_finish = 1'b0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst_n = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;
    tick();
  endtask

  // Bounded wait for mem_burst_req; ok=0 on timeout.
  task automatic wait_mem_req(output bit ok, output int cycles);
    ok = 1'b0;
    cycles = 0;
    for (int i = 0; i < 50; i++) begin
      if (bus.mem_burst_req === 1'b1) begin
        ok = 1'b1;
        break;
      end
      tick();
      cycles++;
    end
  endtask

  task automatic test_reset();
    do_reset();
    for (int i = 0; i < 10; i++) begin
      checks++;
      if (bus.wr_bank !== 2'd0 || bus.rd_bank !== 2'd1 || bus.mem_burst_req !== 1'b0 ||
          bus.read_req_ack !== 1'b0 || bus.wr_burst_ack !== 1'b0 || bus.rd_burst_ack !== 1'b0 ||
          bus.wr_burst_finish !== 1'b0 || bus.rd_burst_finish !== 1'b0) begin
        $display("FAIL reset_idle cyc=%0d wr_bank=%0d rd_bank=%0d req=%b ack=%b (want 0,1,0,0)",
                 i, bus.wr_bank, bus.rd_bank, bus.mem_burst_req, bus.read_req_ack);
        failures++;
      end
      tick();
    end
    checks++;
    if (bus.mem_burst_rw !== 1'b0 || bus.mem_burst_addr !== 24'd0 || bus.mem_burst_len !== 10'd0) begin
      $display("FAIL reset_cmd rw=%b addr=%h len=%0d want 0,0,0", bus.mem_burst_rw, bus.mem_burst_addr, bus.mem_burst_len);
      failures++;
    end
  endtask

  task automatic test_write_burst();
    bit ok;
    int cyc;
    bus.wr_burst_req    = 1'b1;
    bus.wr_burst_offset = 22'h000100;
    bus.wr_burst_len    = 10'd64;
    tick();
    wait_mem_req(ok, cyc);
    checks++;
    if (!ok || cyc !== 0) begin
      $display("FAIL wr_req_latency ok=%0d cycles=%0d want 1,0", ok, cyc);
      failures++;
    end
    checks++;
    if (bus.mem_burst_addr !== {2'd0, 22'h000100} || bus.mem_burst_rw !== 1'b1 || bus.mem_burst_len !== 10'd64) begin
      $display("FAIL wr_cmd addr=%h rw=%b len=%0d want 000100,1,64", bus.mem_burst_addr, bus.mem_burst_rw, bus.mem_burst_len);
      failures++;
    end
    repeat (3) tick();
    checks++;
    if (bus.mem_burst_req !== 1'b1 || bus.wr_burst_ack !== 1'b0) begin
      $display("FAIL wr_req_held req=%b ack=%b want 1,0", bus.mem_burst_req, bus.wr_burst_ack);
      failures++;
    end
    bus.mem_burst_ack = 1'b1;
    #1;
    checks++;
    if (bus.wr_burst_ack !== 1'b1 || bus.rd_burst_ack !== 1'b0) begin
      $display("FAIL wr_ack_pulse wr=%b rd=%b want 1,0", bus.wr_burst_ack, bus.rd_burst_ack);
      failures++;
    end
    tick();
    bus.mem_burst_ack = 1'b0;
    bus.wr_burst_req  = 1'b0;
    #1;
    checks++;
    if (bus.mem_burst_req !== 1'b0 || bus.wr_burst_ack !== 1'b0) begin
      $display("FAIL wr_req_drop req=%b ack=%b want 0,0", bus.mem_burst_req, bus.wr_burst_ack);
      failures++;
    end
    repeat (69) tick();
    checks++;
    if (bus.wr_burst_finish !== 1'b0) begin
      $display("FAIL wr_no_early_finish got=%b want 0", bus.wr_burst_finish);
      failures++;
    end
    bus.mem_burst_finish = 1'b1;
    #1;
    checks++;
    if (bus.wr_burst_finish !== 1'b1 || bus.rd_burst_finish !== 1'b0) begin
      $display("FAIL wr_finish_pulse wr=%b rd=%b want 1,0", bus.wr_burst_finish, bus.rd_burst_finish);
      failures++;
    end
    tick();
    #1;
    // Now idle: a stray finish must be ignored.
    checks++;
    if (bus.wr_burst_finish !== 1'b0 || bus.rd_burst_finish !== 1'b0) begin
      $display("FAIL finish_outside_busy wr=%b rd=%b want 0,0", bus.wr_burst_finish, bus.rd_burst_finish);
      failures++;
    end
    bus.mem_burst_finish = 1'b0;
    tick();
  endtask

  task automatic test_round_robin();
    bit ok;
    int cyc;
    logic exp_rw [4];
`ifdef READ_PRIORITY_EN
    exp_rw = '{1'b0, 1'b0, 1'b0, 1'b0};
`else
    exp_rw = '{1'b0, 1'b1, 1'b0, 1'b1};
`endif
    bus.wr_burst_req    = 1'b1;
    bus.wr_burst_offset = 22'h000200;
    bus.wr_burst_len    = 10'd8;
    bus.rd_burst_req    = 1'b1;
    bus.rd_burst_offset = 22'h000300;
    bus.rd_burst_len    = 10'd16;
    tick();
    for (int b = 0; b < 4; b++) begin
      wait_mem_req(ok, cyc);
      checks++;
      if (!ok) begin
        $display("FAIL rr_timeout burst=%0d", b);
        failures++;
        break;
      end
      checks++;
      if (bus.mem_burst_rw !== exp_rw[b] ||
          bus.mem_burst_addr !== (exp_rw[b] ? {2'd0, 22'h000200} : {2'd1, 22'h000300}) ||
          bus.mem_burst_len !== (exp_rw[b] ? 10'd8 : 10'd16)) begin
        $display("FAIL rr_grant burst=%0d rw=%b addr=%h len=%0d want_rw=%b", b,
                 bus.mem_burst_rw, bus.mem_burst_addr, bus.mem_burst_len, exp_rw[b]);
        failures++;
      end
      bus.mem_burst_ack = 1'b1;
      #1;
      checks++;
      if ({bus.wr_burst_ack, bus.rd_burst_ack} !== (exp_rw[b] ? 2'b10 : 2'b01)) begin
        $display("FAIL rr_ack burst=%0d wr/rd=%b%b", b, bus.wr_burst_ack, bus.rd_burst_ack);
        failures++;
      end
      tick();
      bus.mem_burst_ack    = 1'b0;
      bus.mem_burst_finish = 1'b1;
      #1;
      checks++;
      if ({bus.wr_burst_finish, bus.rd_burst_finish} !== (exp_rw[b] ? 2'b10 : 2'b01)) begin
        $display("FAIL rr_finish burst=%0d wr/rd=%b%b", b, bus.wr_burst_finish, bus.rd_burst_finish);
        failures++;
      end
      tick();
      bus.mem_burst_finish = 1'b0;
    end
    bus.wr_burst_req = 1'b0;
    bus.rd_burst_req = 1'b0;
    repeat (3) tick();
  endtask

  task automatic test_frame_done();
    do_reset();
    bus.wr_frame_done = 1'b1;
    tick();
    bus.wr_frame_done = 1'b0;
    checks++;
    if (bus.wr_bank !== 2'd2 || bus.rd_bank !== 2'd1 || bus.read_req_ack !== 1'b0) begin
      $display("FAIL frame_done_rotate wr=%0d rd=%0d ack=%b want 2,1,0", bus.wr_bank, bus.rd_bank, bus.read_req_ack);
      failures++;
    end
    bus.read_req = 1'b1;
    tick();
    bus.read_req = 1'b0;
    checks++;
    if (bus.rd_bank !== 2'd0 || bus.wr_bank !== 2'd2 || bus.read_req_ack !== 1'b1) begin
      $display("FAIL read_req_new wr=%0d rd=%0d ack=%b want 2,0,1", bus.wr_bank, bus.rd_bank, bus.read_req_ack);
      failures++;
    end
    tick();
    checks++;
    if (bus.read_req_ack !== 1'b0) begin
      $display("FAIL read_ack_one_cycle got=%b want 0", bus.read_req_ack);
      failures++;
    end
    // No new frame: repeat the last one.
    bus.read_req = 1'b1;
    tick();
    bus.read_req = 1'b0;
    checks++;
    if (bus.rd_bank !== 2'd0 || bus.wr_bank !== 2'd2 || bus.read_req_ack !== 1'b1) begin
      $display("FAIL read_req_repeat wr=%0d rd=%0d ack=%b want 2,0,1", bus.wr_bank, bus.rd_bank, bus.read_req_ack);
      failures++;
    end
    tick();
  endtask

  task automatic test_same_cycle();
    do_reset();
    bus.read_req      = 1'b1;
    bus.wr_frame_done = 1'b1;
    tick();
    bus.read_req      = 1'b0;
    bus.wr_frame_done = 1'b0;
    checks++;
    if (bus.rd_bank !== 2'd0 || bus.wr_bank !== 2'd2 || bus.read_req_ack !== 1'b1) begin
      $display("FAIL same_cycle wr=%0d rd=%0d ack=%b want 2,0,1", bus.wr_bank, bus.rd_bank, bus.read_req_ack);
      failures++;
    end
    tick();
  endtask

  task automatic test_reset_mid_burst();
    bit ok;
    int cyc;
    bus.rd_burst_req    = 1'b1;
    bus.rd_burst_offset = 22'h000040;
    bus.rd_burst_len    = 10'd4;
    tick();
    wait_mem_req(ok, cyc);
    checks++;
    if (!ok || bus.mem_burst_addr !== {2'd0, 22'h000040} || bus.mem_burst_rw !== 1'b0) begin
      $display("FAIL mid_rd_cmd ok=%0d addr=%h rw=%b want 1,000040,0", ok, bus.mem_burst_addr, bus.mem_burst_rw);
      failures++;
    end
    bus.mem_burst_ack = 1'b1;
    tick();
    bus.mem_burst_ack = 1'b0;
    bus.rd_burst_req  = 1'b0;
    tick();
    rst_n = 1'b0;
    bus.mem_burst_finish = 1'b1;
    #1;
    checks++;
    if (bus.rd_burst_finish !== 1'b0 || bus.mem_burst_req !== 1'b0 || bus.mem_burst_addr !== 24'd0 ||
        bus.wr_bank !== 2'd0 || bus.rd_bank !== 2'd1) begin
      $display("FAIL reset_mid_burst fin=%b req=%b addr=%h wr=%0d rd=%0d want 0,0,0,0,1",
               bus.rd_burst_finish, bus.mem_burst_req, bus.mem_burst_addr, bus.wr_bank, bus.rd_bank);
      failures++;
    end
    tick();
    bus.mem_burst_finish = 1'b0;
    rst_n = 1'b1;
    tick();
    bus.wr_burst_req    = 1'b1;
    bus.wr_burst_offset = 22'h000010;
    bus.wr_burst_len    = 10'd2;
    tick();
    wait_mem_req(ok, cyc);
    checks++;
    if (!ok || cyc !== 0 || bus.mem_burst_rw !== 1'b1 || bus.mem_burst_addr !== {2'd0, 22'h000010}) begin
      $display("FAIL restart_after_reset ok=%0d cycles=%0d rw=%b addr=%h want 1,0,1,000010",
               ok, cyc, bus.mem_burst_rw, bus.mem_burst_addr);
      failures++;
    end
    // Ack and finish together complete the burst in one step.
    bus.mem_burst_ack    = 1'b1;
    bus.mem_burst_finish = 1'b1;
    #1;
    checks++;
    if (bus.wr_burst_ack !== 1'b1 || bus.wr_burst_finish !== 1'b1) begin
      $display("FAIL ack_finish_same ack=%b fin=%b want 1,1", bus.wr_burst_ack, bus.wr_burst_finish);
      failures++;
    end
    tick();
    bus.mem_burst_ack    = 1'b0;
    bus.mem_burst_finish = 1'b0;
    bus.wr_burst_req     = 1'b0;
    tick();
    checks++;
    if (bus.mem_burst_req !== 1'b0) begin
      $display("FAIL idle_after_ack_finish req=%b want 0", bus.mem_burst_req);
      failures++;
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst_n    = 1'b0;
    clear_inputs();
    test_reset();
    test_write_burst();
    test_round_robin();
    test_frame_done();
    test_same_cycle();
    test_reset_mid_burst();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/frame_buf_sched.md
Name: frame_buf_sched

Overview:
- Scheduler between the video pipeline and the single frame-buffer memory burst port.
- Arbitrates burst requests from a write channel (capture side) and a read channel (display side feeding the timing/data block).
- Owns triple-buffer bank rotation, and answers the display frame-start handshake (read_req/read_req_ack).
- Each burst address is formed as {bank, offset}.

Parameters:
- OFFSET_WIDTH, 22: per-bank word offset width; memory address width is OFFSET_WIDTH+2.
- LEN_WIDTH, 10: burst length field width.

Ports:
- clk  in  1  system/video clock
- rst_n  in  1  asynchronous active-low reset
- read_req  in  1  display frame-start request, level, held until acked
- read_req_ack  out  1  one-cycle ack; rd_bank updated in the same cycle
- wr_frame_done  in  1  one-cycle pulse, writer finished a frame
- wr_burst_req  in  1  write burst request, held until wr_burst_ack
- wr_burst_len  in  LEN_WIDTH  write burst length
- wr_burst_offset  in  OFFSET_WIDTH  write offset within bank
- wr_burst_ack  out  1  one-cycle pulse, write request accepted by memory
- wr_burst_finish  out  1  one-cycle pulse, write burst complete
- rd_burst_req, rd_burst_len, rd_burst_offset, rd_burst_ack, rd_burst_finish: same as write, read channel
- mem_burst_req  out  1  held until mem_burst_ack
- mem_burst_rw  out  1  1=write, 0=read
- mem_burst_addr  out  OFFSET_WIDTH+2  {bank, offset}
- mem_burst_len  out  LEN_WIDTH
- mem_burst_ack  in  1  one-cycle accept
- mem_burst_finish  in  1  one-cycle burst done
- wr_bank  out  2  bank being written
- rd_bank  out  2  bank being displayed

Behaviour:
- Reset values: all pulses and mem_burst_req = 0; mem_burst_rw/addr/len = 0; wr_bank=0; rd_bank=1; internal last_bank=1; state IDLE; rr_last=WR.
- Reset asserted mid-burst aborts immediately; no finish pulse is issued.
- Bank invariant: wr_bank != rd_bank at all times. Banks take values 0..2 only.
- wr_frame_done: last_bank <= wr_bank; wr_bank <= the bank in {0,1,2} that is neither the old wr_bank nor rd_bank.
- read_req, only when in IDLE or between bursts, and read_req_ack not asserted the previous cycle: rd_bank <= last_bank; read_req_ack=1 for one cycle. No new frame written yet: rd_bank stays at last_bank (repeat frame).
- read_req and wr_frame_done in the same cycle: completing frame is shown. rd_bank <= old wr_bank; last_bank <= old wr_bank; wr_bank <= remaining third bank.
- FSM states:
  - IDLE: any channel request -> REQ. Winner picked by round-robin (opposite of rr_last when both request, else the sole requester). Grant latched into sel; mem_burst_* driven from the latched channel fields and the bank snapshot (wr_bank for writes, rd_bank for reads).
  - REQ: mem_burst_req=1 until mem_burst_ack. On ack, pulse the selected channel's *_burst_ack in the same cycle, drop mem_burst_req, -> BUSY.
  - BUSY: wait mem_burst_finish. Then pulse the selected channel's *_burst_finish the same cycle; rr_last <= sel; -> IDLE.
- Bank snapshot is frozen from IDLE->REQ until BUSY exit. Bank changes during a burst affect only the next burst.
- mem_burst_ack and mem_burst_finish in the same cycle while in REQ: treat as ack then finish. Both channel pulses fire; -> IDLE.
- mem_burst_finish outside BUSY: ignored.
- Minimum turnaround is 1 IDLE cycle between bursts.

Optional Feature:
- Macro READ_PRIORITY_EN.
- Defined: read channel always wins simultaneous requests (display underflow protection); rr_last unused.
- Undefined: round-robin as above.

Test Plan:
- Reset release, no requests -> wr_bank=0, rd_bank=1, all outputs 0, state IDLE for 10 cycles.
- Write burst: offset 0x100, len 64; mem_burst_ack 3 cycles later; finish 70 cycles later -> mem_burst_addr={2'd0,0x100}, rw=1, len=64. wr_burst_ack coincides with mem ack; wr_burst_finish coincides with mem finish.
- Both channels request every cycle, 4 bursts -> grant order RD,WR,RD,WR (round-robin). With READ_PRIORITY_EN: RD,RD,RD,RD.
- wr_frame_done, then read_req -> wr_bank 0->2, last_bank=0; then rd_bank=0 with read_req_ack pulse.
- read_req and wr_frame_done same cycle (wr_bank=0, rd_bank=1) -> rd_bank=0, wr_bank=2, ack pulse.
- rst_n low during BUSY -> outputs to reset values; no finish pulse; next request restarts at REQ.
